// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH x 8 first-word fall-through FIFO with a registered occupancy count.
// Define BYTE_FIFO_ERR_EN to add sticky o_overflow / o_underflow flags.
// When the macro is undefined, the flags and their ports are not built.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [7:0]               i_wdata,
    input  logic                     i_re,
    output logic [7:0]               o_rdata,
    output logic [$clog2(DEPTH):0]   o_records,
    output logic                     o_empty,
`ifdef BYTE_FIFO_ERR_EN
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_underflow
`else
    output logic                     o_full
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_next;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance uses the registered flags, so a write into a full FIFO is
    // dropped even when a read frees a slot on the same edge.
    always_comb begin
        wr_acc = i_we & ~o_full;
        rd_acc = i_re & ~o_empty;
    end

    // Next occupancy: simultaneous accepted write and read cancel out.
    always_comb begin
        cnt_next = o_records;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_next = o_records + CW'(1);
            2'b01:   cnt_next = o_records - CW'(1);
            default: cnt_next = o_records;
        endcase
    end

    // Storage array, deliberately unreset; contents are hidden while empty.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_reset) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    // Pointers, count, and empty/full registered together so the flags never glitch.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_records <= '0;
            o_empty   <= 1'b1;
            o_full    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            o_records <= cnt_next;
            o_empty   <= (cnt_next == '0);
            o_full    <= (cnt_next == FULL_CNT);
        end
    end

    // Fall-through head of the queue.
    always_comb begin
        o_rdata = mem[rd_ptr];
    end

`ifdef BYTE_FIFO_ERR_EN
    // Sticky error flags; only reset clears them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_we && o_full) begin
                o_overflow <= 1'b1;
            end
            if (i_re && o_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_byte_fifo.sv
// tb_byte_fifo: directed and random checks of byte_fifo against a queue model.
// The error-flag checks are compiled only when BYTE_FIFO_ERR_EN is defined.
module tb_byte_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_we = 1'b0;
    logic          i_re = 1'b0;
    logic [7:0]    i_wdata = '0;
    logic [7:0]    o_rdata;
    logic [CW-1:0] o_records;
    logic          o_empty;
    logic          o_full;
`ifdef BYTE_FIFO_ERR_EN
    logic          o_overflow;
    logic          o_underflow;
    logic          m_ov;
    logic          m_uf;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: plain queue of stored bytes.
    logic [7:0] q[$];

    byte_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_we       (i_we),
        .i_wdata    (i_wdata),
        .i_re       (i_re),
        .o_rdata    (o_rdata),
        .o_records  (o_records),
        .o_empty    (o_empty),
`ifdef BYTE_FIFO_ERR_EN
        .o_full     (o_full),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
`else
        .o_full     (o_full)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Clear the model alongside a DUT reset.
    task automatic model_clear();
        q.delete();
`ifdef BYTE_FIFO_ERR_EN
        m_ov = 1'b0;
        m_uf = 1'b0;
`endif
    endtask

    // Short reset pulse placed between clock edges; called at posedge+1.
    task automatic apply_reset();
        i_reset = 1'b1;
        #3;
        i_reset = 1'b0;
        model_clear();
    endtask

    // Drive one clock with the given strobes; returns 1 time unit after the edge.
    task automatic do_cycle(input logic we, input logic re, input logic [7:0] d);
        bit full_now;
        bit empty_now;
        i_we = we;
        i_re = re;
        i_wdata = d;
        @(posedge i_clk);
        full_now  = (q.size() == DEPTH);
        empty_now = (q.size() == 0);
`ifdef BYTE_FIFO_ERR_EN
        if (we && full_now) m_ov = 1'b1;
        if (re && empty_now) m_uf = 1'b1;
`endif
        if (re && !empty_now) void'(q.pop_front());
        if (we && !full_now) q.push_back(d);
        #1;
        i_we = 1'b0;
        i_re = 1'b0;
    endtask

    task automatic test_reset();
        // Reset held across an edge with strobes active must ignore them.
        i_reset = 1'b1;
        i_we = 1'b1;
        i_re = 1'b1;
        i_wdata = 8'h5A;
        @(posedge i_clk);
        #1;
        i_we = 1'b0;
        i_re = 1'b0;
        #2;
        i_reset = 1'b0;
        model_clear();
        n_tests++;
        if (o_records !== '0) begin
            n_fail++;
            $display("FAIL reset_records: got %0d want 0", o_records);
        end
        n_tests++;
        if (o_empty !== 1'b1 || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got empty=%b full=%b want empty=1 full=0", o_empty, o_full);
        end
`ifdef BYTE_FIFO_ERR_EN
        n_tests++;
        if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got ov=%b uf=%b want 0 0", o_overflow, o_underflow);
        end
`endif
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_single();
        apply_reset();
        do_cycle(1'b1, 1'b0, 8'hA5);
        n_tests++;
        if (o_empty !== 1'b0 || o_records !== CW'(1) || o_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_write: got empty=%b rec=%0d data=%h want 0 1 a5", o_empty, o_records, o_rdata);
        end
        do_cycle(1'b0, 1'b1, 8'h00);
        n_tests++;
        if (o_empty !== 1'b1 || o_records !== '0) begin
            n_fail++;
            $display("FAIL single_read: got empty=%b rec=%0d want 1 0", o_empty, o_records);
        end
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'(i));
        n_tests++;
        if (o_full !== 1'b1 || o_records !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b rec=%0d want 1 %0d", o_full, o_records, DEPTH);
        end
        do_cycle(1'b1, 1'b0, 8'hFF);
        n_tests++;
        if (o_records !== CW'(DEPTH) || o_full !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_write: got rec=%0d full=%b want %0d 1", o_records, o_full, DEPTH);
        end
`ifdef BYTE_FIFO_ERR_EN
        n_tests++;
        if (o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flag: got %b want 1", o_overflow);
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (o_rdata !== 8'(i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, o_rdata, 8'(i));
            end
            do_cycle(1'b0, 1'b1, 8'h00);
        end
        n_tests++;
        if (o_empty !== 1'b1 || o_records !== '0) begin
            n_fail++;
            $display("FAIL drain_empty: got empty=%b rec=%0d want 1 0", o_empty, o_records);
        end
    endtask

    task automatic test_streaming();
        apply_reset();
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            logic [7:0] head;
            head = q[0];
            n_tests++;
            if (o_rdata !== head) begin
                n_fail++;
                $display("FAIL stream_data[%0d]: got %h want %h", i, o_rdata, head);
            end
            do_cycle(1'b1, 1'b1, 8'($urandom));
            n_tests++;
            if (o_records !== CW'(4)) begin
                n_fail++;
                $display("FAIL stream_count[%0d]: got %0d want 4", i, o_records);
            end
        end
    endtask

    task automatic test_empty_both();
        apply_reset();
        do_cycle(1'b1, 1'b1, 8'h3C);
        n_tests++;
        if (o_records !== CW'(1) || o_rdata !== 8'h3C || o_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_both: got rec=%0d data=%h empty=%b want 1 3c 0", o_records, o_rdata, o_empty);
        end
`ifdef BYTE_FIFO_ERR_EN
        n_tests++;
        if (o_underflow !== 1'b1 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_flag: got uf=%b ov=%b want 1 0", o_underflow, o_overflow);
        end
`endif
    endtask

    task automatic test_full_both();
        logic [7:0] second;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'($urandom));
        second = q[1];
        do_cycle(1'b1, 1'b1, 8'($urandom));
        n_tests++;
        if (o_records !== CW'(DEPTH - 1) || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL full_both_count: got rec=%0d full=%b want %0d 0", o_records, o_full, DEPTH - 1);
        end
        n_tests++;
        if (o_rdata !== second) begin
            n_fail++;
            $display("FAIL full_both_data: got %h want %h", o_rdata, second);
        end
`ifdef BYTE_FIFO_ERR_EN
        n_tests++;
        if (o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL full_both_ov: got %b want 1", o_overflow);
        end
`endif
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 8'($urandom));
        n_tests++;
        if (o_records !== CW'(5)) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %0d want 5", o_records);
        end
        #2;
        i_reset = 1'b1;
        #1;
        n_tests++;
        if (o_records !== '0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got rec=%0d empty=%b full=%b want 0 1 0", o_records, o_empty, o_full);
        end
`ifdef BYTE_FIFO_ERR_EN
        n_tests++;
        if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_err: got ov=%b uf=%b want 0 0", o_overflow, o_underflow);
        end
`endif
        #2;
        i_reset = 1'b0;
        model_clear();
        @(posedge i_clk);
        #1;
        n_tests++;
        if (o_records !== '0 || o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: got rec=%0d empty=%b want 0 1", o_records, o_empty);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            logic we;
            logic re;
            // Alternate phases biased toward filling and toward draining.
            if ((i / 50) % 2 == 0) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            do_cycle(we, re, 8'($urandom));
            n_tests++;
            if (o_records !== CW'(q.size()) || o_empty !== (q.size() == 0) ||
                o_full !== (q.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got rec=%0d empty=%b full=%b want rec=%0d", i, o_records, o_empty, o_full, q.size());
            end
            if (q.size() != 0) begin
                n_tests++;
                if (o_rdata !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, o_rdata, q[0]);
                end
            end
`ifdef BYTE_FIFO_ERR_EN
            n_tests++;
            if (o_overflow !== m_ov || o_underflow !== m_uf) begin
                n_fail++;
                $display("FAIL rand_err[%0d]: got ov=%b uf=%b want %b %b", i, o_overflow, o_underflow, m_ov, m_uf);
            end
`endif
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_fill_overflow();
        test_streaming();
        test_empty_both();
        test_full_both();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_fifo.md
BYTE_FIFO -- requirements
Module: byte_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 8-bit entries; power of two, 2..256.
REQ-002 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port i_reset, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port i_we, input, 1, write strobe from the upstream arbiter, one byte per cycle while high.
REQ-005 SHALL have port i_wdata, input, 8, write byte, sampled on the edge where i_we is high.
REQ-006 SHALL have port i_re, input, 1, read strobe from the consumer.
REQ-007 SHALL have port o_rdata, output, 8, head entry, first-word fall-through.
REQ-008 SHALL have port o_records, output, clog2(DEPTH)+1, current occupancy, range 0..DEPTH.
REQ-009 SHALL have port o_empty, output, 1, high when o_records == 0.
REQ-010 SHALL have port o_full, output, 1, high when o_records == DEPTH.
REQ-011 SHALL have port o_overflow, output, 1, sticky write-when-full flag; present only with BYTE_FIFO_ERR_EN.
REQ-012 SHALL have port o_underflow, output, 1, sticky read-when-empty flag; present only with BYTE_FIFO_ERR_EN.

Function
REQ-013 SHALL store entries in a DEPTH x 8 register array addressed by wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-014 SHALL accept a write (store i_wdata at wr_ptr, advance wr_ptr) on an edge with i_we high and o_full low.
REQ-015 SHALL drop a write with i_we high and o_full high; nothing stored, pointers and count unchanged, even if i_re is also high that cycle.
REQ-016 SHALL accept a read (advance rd_ptr) on an edge with i_re high and o_empty low.
REQ-017 SHALL ignore a read with i_re high and o_empty high, even if i_we is also high that cycle; the written byte is still stored.
REQ-018 SHALL drive o_rdata = mem[rd_ptr] continuously; o_rdata is don't-care while o_empty is high.
REQ-019 SHALL show a byte written into an empty FIFO on o_rdata, with o_empty low, in the cycle after the write edge (1-cycle latency).
REQ-020 SHALL update o_records at the edge: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
REQ-021 SHALL derive o_full and o_empty from the registered count, glitch-free, and keep them valid in the same cycle as o_records.
REQ-022 SHALL keep o_rdata stable while no read is accepted, including while writes are accepted.

Reset
REQ-023 SHALL on i_reset high, immediately and independent of i_clk: wr_ptr=0, rd_ptr=0, o_records=0, o_empty=1, o_full=0, o_overflow=0, o_underflow=0.
REQ-024 SHALL leave array contents unreset; they are unobservable while o_empty is high.
REQ-025 SHALL ignore i_we and i_re while i_reset is high, and resume normal operation on the first edge after deassertion.
REQ-026 SHALL discard all stored data on a reset asserted mid-operation; there is no partial retention.

Configuration
REQ-027 SHALL compile o_overflow, o_underflow and their logic only when macro BYTE_FIFO_ERR_EN is defined.
REQ-028 SHALL with BYTE_FIFO_ERR_EN: set o_overflow on the edge after a dropped write (REQ-015) and set o_underflow on the edge after an ignored read (REQ-017); both cleared only by reset.
REQ-029 SHALL without BYTE_FIFO_ERR_EN: omit both ports; the data path behaves identically.

Verification
REQ-030 SHALL cover: after reset, write 0xA5 once -> next cycle o_empty=0, o_records=1, o_rdata=0xA5; one read -> o_empty=1, o_records=0.
REQ-031 SHALL cover: DEPTH=8, write 0x00..0x07 -> o_full=1, o_records=8; write 0xFF -> dropped, o_records=8, o_overflow=1 (ERR_EN); 8 reads -> 0x00..0x07 in order.
REQ-032 SHALL cover: fill 4, then 20 cycles of simultaneous write/read -> o_records stays 4, output order preserved across pointer wrap.
REQ-033 SHALL cover: empty FIFO, i_we=1 with 0x3C and i_re=1 same cycle -> read ignored, o_records=1, o_rdata=0x3C, o_underflow=1 (ERR_EN).
REQ-034 SHALL cover: full FIFO, simultaneous write/read -> write dropped, o_records=7, next o_rdata is the second-oldest byte.
REQ-035 SHALL cover: i_reset pulsed between clock edges with 5 entries stored -> o_records=0, o_empty=1 before the next edge, flags cleared.
